// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan-out of a 64x64 1-bit frame buffer, upscaled by 2**SCALE_LOG2 into a fixed window.
// Optional macro VGA_BORDER_EN draws a 1-pixel red frame around the window once armed.
module vga_frame_reader #(
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned X_OFFSET   = 192,
  parameter int unsigned Y_OFFSET   = 112,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic        clock_50MHz,
  input  logic        reset_n,
  input  logic        frame_ready,
  output logic [11:0] rdaddress,
  input  logic        rddata,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        display_active,
  output logic        frame_start
);

  localparam int unsigned WIN = 64 << SCALE_LOG2;

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd752;
  localparam logic [9:0] H_MAX    = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd492;
  localparam logic [9:0] V_MAX    = 10'd524;

  localparam logic [9:0] X_LO = 10'(X_OFFSET);
  localparam logic [9:0] X_HI = 10'(X_OFFSET + WIN);
  localparam logic [9:0] Y_LO = 10'(Y_OFFSET);
  localparam logic [9:0] Y_HI = 10'(Y_OFFSET + WIN);

  logic        pix_en;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        pending;
  logic        armed;
  logic [11:0] rgb;

  logic        in_win_c;
  logic        visible_c;
  logic        wrap_c;
  logic [9:0]  dx_c;
  logic [9:0]  dy_c;
  logic [11:0] rgb_nxt_c;

  // Window decode and frame-buffer address, both straight from the live counters
  always_comb begin
    in_win_c  = (h_cnt >= X_LO) && (h_cnt < X_HI) && (v_cnt >= Y_LO) && (v_cnt < Y_HI);
    visible_c = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    wrap_c    = (h_cnt == H_MAX) && (v_cnt == V_MAX);
    dx_c      = h_cnt - X_LO;
    dy_c      = v_cnt - Y_LO;
    rdaddress = '0;
    if (in_win_c)
      rdaddress = {6'(dy_c >> SCALE_LOG2), 6'(dx_c >> SCALE_LOG2)};
  end

`ifdef VGA_BORDER_EN
  localparam logic [9:0] X_BL = 10'(X_OFFSET - 1);
  localparam logic [9:0] Y_BL = 10'(Y_OFFSET - 1);

  logic on_border_c;

  always_comb begin
    on_border_c = armed
                  && (h_cnt >= X_BL) && (h_cnt <= X_HI)
                  && (v_cnt >= Y_BL) && (v_cnt <= Y_HI)
                  && ((h_cnt == X_BL) || (h_cnt == X_HI) || (v_cnt == Y_BL) || (v_cnt == Y_HI));
  end
`endif

  // Colour priority: blanking, armed image, optional border, background
  always_comb begin
    rgb_nxt_c = BG_COLOR;
    if (!visible_c)
      rgb_nxt_c = 12'h000;
    else if (in_win_c && armed)
      rgb_nxt_c = rddata ? 12'hFFF : 12'h000;
`ifdef VGA_BORDER_EN
    else if (on_border_c)
      rgb_nxt_c = 12'hF00;
`endif
  end

  // Counters and outputs advance on pixel ticks; the RAM reads on the clock in between
  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      pix_en         <= 1'b0;
      h_cnt          <= '0;
      v_cnt          <= '0;
      pending        <= 1'b0;
      armed          <= 1'b0;
      hsync          <= 1'b1;
      vsync          <= 1'b1;
      display_active <= 1'b0;
      rgb            <= '0;
      frame_start    <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      pending     <= frame_ready;
      frame_start <= 1'b0;
      if (pix_en) begin
        hsync          <= !((h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E));
        vsync          <= !((v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E));
        display_active <= visible_c;
        rgb            <= rgb_nxt_c;
        if (h_cnt == H_MAX) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
        // Arm only at a frame boundary so a late frame_ready never tears the image
        if (wrap_c) begin
          frame_start <= 1'b1;
          if (pending)
            armed <= 1'b1;
        end
      end
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: per-clock comparison against a position-based timing/colour model.
module tb_vga_frame_reader;

  localparam int XO  = 192;
  localparam int YO  = 112;
  localparam int WIN = 256;
  localparam int SCL = 4;
  localparam int HT  = 800;
  localparam int VT  = 525;
  localparam int FR  = HT * VT;

  logic        clock_50MHz = 1'b0;
  logic        reset_n;
  logic        frame_ready;
  logic [11:0] rdaddress;
  logic        rddata = 1'b0;
  logic        hsync, vsync;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        display_active;
  logic        frame_start;

  always #10 clock_50MHz = ~clock_50MHz;

  vga_frame_reader dut (
    .clock_50MHz   (clock_50MHz),
    .reset_n       (reset_n),
    .frame_ready   (frame_ready),
    .rdaddress     (rdaddress),
    .rddata        (rddata),
    .hsync         (hsync),
    .vsync         (vsync),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b),
    .display_active(display_active),
    .frame_start   (frame_start)
  );

  bit mem [4096];
  always @(posedge clock_50MHz) rddata <= mem[rdaddress];

  typedef struct {
    int h;
    int v;
    int addr;
  } vec_t;
  vec_t tbl [8];
  int   tidx;

  int checks = 0;
  int errors = 0;
  int e;
  bit ready_set;
  int ready_m;
  int hs_fall1, hs_fall2, hs_rise1, vs_fall1, vs_rise1, fs_first;
  logic prev_hs, prev_vs;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, e, act, exp);
    end
  endtask

  function automatic bit in_win(input int p);
    int h = p % HT;
    int v = (p / HT) % VT;
    return h >= XO && h < XO + WIN && v >= YO && v < YO + WIN;
  endfunction

  function automatic int addr_of(input int p);
    int h = p % HT;
    int v = (p / HT) % VT;
    if (!in_win(p)) return 0;
    return ((v - YO) / SCL) * 64 + (h - XO) / SCL;
  endfunction

  function automatic int rgb_of(input int p);
    int h = p % HT;
    int v = (p / HT) % VT;
    bit arm = ready_set && ((p / FR) > (ready_m / FR));
    if (!(h < 640 && v < 480)) return 0;
    if (in_win(p) && arm) return mem[addr_of(p)] ? 'hFFF : 'h000;
`ifdef VGA_BORDER_EN
    if (arm && h >= XO - 1 && h <= XO + WIN && v >= YO - 1 && v <= YO + WIN) return 'hF00;
`endif
    return 'h000;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
    chk({tag, "_de"}, int'(display_active), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
    chk({tag, "_addr"}, int'(rdaddress), 0);
  endtask

  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) begin
      int m, p, h, v, exp_rgb, act_rgb;
      bit exp_hs, exp_vs, exp_de, exp_fs;
      @(posedge clock_50MHz);
      e++;
      @(negedge clock_50MHz);
      m = e / 2;
      if (m == 0) begin
        exp_hs = 1'b1; exp_vs = 1'b1; exp_de = 1'b0; exp_rgb = 0;
        p = -1;
      end else begin
        p = m - 1;
        h = p % HT;
        v = (p / HT) % VT;
        exp_hs  = !(h >= 656 && h < 752);
        exp_vs  = !(v >= 490 && v < 492);
        exp_de  = h < 640 && v < 480;
        exp_rgb = rgb_of(p);
      end
      exp_fs  = (e % 2 == 0) && m > 0 && (m % FR == 0);
      act_rgb = int'({vga_r, vga_g, vga_b});
      chk("hsync", int'(hsync), int'(exp_hs));
      chk("vsync", int'(vsync), int'(exp_vs));
      chk("display_active", int'(display_active), int'(exp_de));
      chk("rgb", act_rgb, exp_rgb);
      chk("frame_start", int'(frame_start), int'(exp_fs));
      chk("rdaddress", int'(rdaddress), addr_of(m));

      if (e % 2 == 0) begin
        if (m < FR && tidx < 8 && m % HT == tbl[tidx].h && m / HT == tbl[tidx].v) begin
          chk($sformatf("addr_tbl%0d", tidx), int'(rdaddress), tbl[tidx].addr);
          tidx++;
        end
        if (p >= YO * HT + XO + 4 && p <= YO * HT + XO + 7)
          chk("unarmed_px1", act_rgb, 'h000);
        if (p >= FR + YO * HT + XO + 4 && p <= FR + YO * HT + XO + 7)
          chk("armed_px1", act_rgb, 'hFFF);
        if (p == FR + YO * HT + XO)
          chk("armed_px0", act_rgb, 'h000);
        if (p == FR + (YO + 10) * HT + XO - 1)
`ifdef VGA_BORDER_EN
          chk("border_px", act_rgb, 'hF00);
`else
          chk("border_px", act_rgb, 'h000);
`endif
      end

      if (prev_hs && !hsync) begin
        if (hs_fall1 < 0) hs_fall1 = e;
        else if (hs_fall2 < 0) hs_fall2 = e;
      end
      if (!prev_hs && hsync && hs_rise1 < 0) hs_rise1 = e;
      if (prev_vs && !vsync && vs_fall1 < 0) vs_fall1 = e;
      if (!prev_vs && vsync && vs_rise1 < 0) vs_rise1 = e;
      if (frame_start && fs_first < 0) fs_first = e;
      prev_hs = hsync;
      prev_vs = vsync;

      if (e % 2 == 0 && m == 200 * HT && !ready_set) begin
        frame_ready = 1'b1;
        ready_set   = 1'b1;
        ready_m     = m;
      end
      if (e % 2 == 0 && m == FR + 50 * HT)
        frame_ready = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{h: XO - 1,   v: YO,       addr: 0};
    tbl[1] = '{h: XO,       v: YO,       addr: 0};
    tbl[2] = '{h: XO + 4,   v: YO,       addr: 1};
    tbl[3] = '{h: XO + 255, v: YO,       addr: 63};
    tbl[4] = '{h: XO + 256, v: YO,       addr: 0};
    tbl[5] = '{h: XO + 4,   v: YO + 4,   addr: 65};
    tbl[6] = '{h: XO + 8,   v: YO + 8,   addr: 130};
    tbl[7] = '{h: XO + 255, v: YO + 255, addr: 4095};
    tidx = 0;

    for (int a = 0; a < 4096; a++) mem[a] = 1'($urandom_range(0, 1));
    mem[0] = 1'b0;
    mem[1] = 1'b1;

    ready_set = 1'b0; ready_m = 0;
    hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1;
    vs_fall1 = -1; vs_rise1 = -1; fs_first = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
    e = 0;

    reset_n = 1'b0;
    frame_ready = 1'b0;
    repeat (5) @(negedge clock_50MHz);
    check_reset_state("rst");
    reset_n = 1'b1;

    // One full frame (armed mid-way) plus the top of the next, which shows the image
    run_edges(2 * (FR + 124 * HT));

    chk("hs_first_fall", hs_fall1, 2 * 657);
    chk("hs_low_clocks", hs_rise1 - hs_fall1, 192);
    chk("hs_period_clocks", hs_fall2 - hs_fall1, 1600);
    chk("vs_first_fall", vs_fall1, 2 * (490 * HT + 1));
    chk("vs_low_clocks", vs_rise1 - vs_fall1, 3200);
    chk("fs_first_edge", fs_first, 2 * FR);
    chk("addr_tbl_seen", tidx, 8);

    // Mid-line reset aborts immediately and restarts un-armed from (0,0)
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_state("midrst");
    repeat (3) @(negedge clock_50MHz);
    check_reset_state("midrst_hold");
    ready_set = 1'b0;
    e = 0;
    reset_n = 1'b1;
    run_edges(4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
